// File: rtl/vector_add_rr_scheduler.sv
// Round-robin owner of a shared serial vector adder: issues one strobe per
// element, counts returned results, then pulses done to the owner and releases.
module vector_add_rr_scheduler #(
  parameter int unsigned NUM_ELEMS = 10,
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 req0,
  input  logic                 req1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 readyForNewDataSeries,
  output logic                 adderInReady,
  output logic [IDX_WIDTH-1:0] elemIdx,
  input  logic                 adderOutReady,
  output logic                 done0,
  output logic                 done1,
  output logic                 protocolError
);

  localparam int unsigned CNT_W = IDX_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEMS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     issue_q, issue_d;
  logic [CNT_W-1:0]     res_q, res_d;
  logic [CNT_W-1:0]     res_next;
  logic                 strobe_q, strobe_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err_q, err_d;
  logic                 win1;

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    last_d   = last_q;
    issue_d  = issue_q;
    res_d    = res_q;
    res_next = res_q;
    strobe_d = 1'b0;
    idx_d    = idx_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = err_q;
    win1     = 1'b0;

    // Results outside an active operation, or beyond the vector length, are errors
    if (adderOutReady) begin
      if (state_q == IDLE || state_q == DONE || res_q == LAST_CNT) begin
        err_d = 1'b1;
      end else begin
        res_next = res_q + ONE_CNT;
      end
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win1    = req1 & (~req0 | ~last_q);
          state_d = ISSUE;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          last_d  = win1;
        end
      end
      ISSUE: begin
        res_d = res_next;
        if (issue_q != LAST_CNT) begin
          strobe_d = 1'b1;
          idx_d    = issue_q[IDX_WIDTH-1:0];
          issue_d  = issue_q + ONE_CNT;
        end else if (res_next == LAST_CNT) begin
          state_d = DONE;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        res_d = res_next;
        if (res_next == LAST_CNT) begin
          state_d = DONE;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        issue_d = '0;
        res_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; a disabled edge only clears the one-cycle strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      last_q   <= 1'b1;
      issue_q  <= '0;
      res_q    <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      last_q   <= last_d;
      issue_q  <= issue_d;
      res_q    <= res_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
    end else begin
      strobe_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end
  end

  assign gnt0                  = gnt0_q;
  assign gnt1                  = gnt1_q;
  assign adderInReady          = strobe_q;
  assign elemIdx               = idx_q;
  assign done0                 = done0_q;
  assign done1                 = done1_q;
  assign protocolError         = err_q;
  assign readyForNewDataSeries = (state_q == IDLE);

endmodule
